bcd_scan_display: RTL and testbench

- Downstream consumer of the team's 4-bit ripple decade counters.
- Takes NDIG cascaded BCD digits, synchronises them into the clk domain and filters ripple glitches. Ripple outputs settle bit-by-bit and are asynchronous to clk.
- Time-multiplexes the digits onto one active-low 7-segment bus with active-low digit enables.
- Flags any digit outside 0-9.

---
 rtl/bcd_scan_display.sv | 141 ++++++++++++++
 tb/tb_bcd_scan_display.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_display.sv
`default_nettype none
// ============================================================================
// Module   : bcd_scan_display
// Brief    : Scans NDIG ripple-counter BCD digits onto a shared active-low
//            7-segment bus, with glitch filtering and invalid-digit flagging.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_scan_display #(
    parameter int NDIG        = 4,
    parameter int SCAN_DIV    = 1000,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4*NDIG-1:0]   digit_in,
    input  logic                blank_lz,
    output logic [6:0]          seg,
    output logic [NDIG-1:0]     an,
    output logic                dig_err,
    output logic                upd
);

    localparam int         W        = 4 * NDIG;
    localparam int         IDX_W    = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int         PRE_W    = $clog2(SCAN_DIV);
    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    logic [W-1:0]     sync_ff [SYNC_STAGES];
    logic [W-1:0]     sync_q;
    logic [W-1:0]     prev_sync;
    logic [W-1:0]     held;
    logic [PRE_W-1:0] presc;
    logic [IDX_W-1:0] idx;
    logic             pre_tc;
    logic [3:0]       cur_dig;
    logic             cur_blank;
    logic             any_bad;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    // Ripple outputs are asynchronous to clk; every bit gets its own chain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_ff[i] <= '0;
            end
        end else begin
            sync_ff[0] <= digit_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_ff[i] <= sync_ff[i-1];
            end
        end
    end

    assign sync_q = sync_ff[SYNC_STAGES-1];

    // A word must be seen on two consecutive cycles before it is accepted,
    // so single-cycle ripple transients never reach the held set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_sync <= '0;
            held      <= '0;
            upd       <= 1'b0;
        end else begin
            prev_sync <= sync_q;
            if ((sync_q == prev_sync) && (sync_q != held)) begin
                held <= sync_q;
                upd  <= 1'b1;
            end else begin
                upd  <= 1'b0;
            end
        end
    end

    assign pre_tc = (presc == PRE_W'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc <= '0;
            idx   <= '0;
        end else begin
            if (pre_tc) begin
                presc <= '0;
                if (idx == IDX_W'(NDIG - 1)) begin
                    idx <= '0;
                end else begin
                    idx <= idx + 1'b1;
                end
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    // Digit k is blank when it and everything above it is zero.
    always_comb begin
        cur_dig   = 4'd0;
        cur_blank = 1'b0;
        any_bad   = 1'b0;
        for (int k = 0; k < NDIG; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_dig   = held[4*k +: 4];
                cur_blank = blank_lz && (k != 0) && ((held >> (4*k)) == '0);
            end
            if (held[4*k +: 4] > 4'd9) begin
                any_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg     <= SEG_OFF;
            an      <= '1;
            dig_err <= 1'b0;
        end else begin
            seg     <= cur_blank ? SEG_OFF : bcd_to_seg(cur_dig);
            an      <= ~(NDIG'(1) << idx);
            dig_err <= any_bad;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd_scan_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_scan_display
// Brief    : Randomised and directed stimulus for bcd_scan_display against a
//            history-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_scan_display;

    localparam int NDIG        = 4;
    localparam int SCAN_DIV    = 4;
    localparam int SYNC_STAGES = 2;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic [15:0] digit_in = 16'h0000;
    logic        blank_lz = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dig_err;
    logic        upd;

    bcd_scan_display #(
        .NDIG        (NDIG),
        .SCAN_DIV    (SCAN_DIV),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .digit_in (digit_in),
        .blank_lz (blank_lz),
        .seg      (seg),
        .an       (an),
        .dig_err  (dig_err),
        .upd      (upd)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: what digit_in looked like at each past edge decides
    // what is held; the displayed digit follows from the edge count alone.
    logic [6:0]  seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                  7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                                  7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
    logic [15:0] hist [SYNC_STAGES+1];
    logic [15:0] m_held;
    int          m_edges;
    int          mi;
    logic [3:0]  md;
    logic [15:0] ms, mp;
    logic [6:0]  exp_seg;
    logic [3:0]  exp_an;
    logic        exp_err;
    logic        exp_upd;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i <= SYNC_STAGES; i++) hist[i] = 16'h0;
            m_held  = 16'h0;
            m_edges = 0;
            exp_seg = 7'h7F;
            exp_an  = 4'hF;
            exp_err = 1'b0;
            exp_upd = 1'b0;
        end else begin
            mi      = (m_edges / SCAN_DIV) % NDIG;
            md      = m_held[4*mi +: 4];
            exp_an  = ~(4'b0001 << mi);
            exp_seg = (blank_lz && mi > 0 && (m_held >> (4*mi)) == 16'h0) ? 7'h7F : seg_tab[md];
            exp_err = 1'b0;
            for (int k = 0; k < NDIG; k++) begin
                if (m_held[4*k +: 4] > 4'd9) exp_err = 1'b1;
            end
            ms = hist[SYNC_STAGES-1];
            mp = hist[SYNC_STAGES];
            if (ms == mp && ms != m_held) begin
                m_held  = ms;
                exp_upd = 1'b1;
            end else begin
                exp_upd = 1'b0;
            end
            for (int i = SYNC_STAGES; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = digit_in;
            m_edges++;
        end
    end

    task automatic compare_all();
        check_eq("seg", seg, exp_seg);
        check_eq("an", an, exp_an);
        check_eq("dig_err", dig_err, exp_err);
        check_eq("upd", upd, exp_upd);
    endtask

    // Inputs change right after a falling edge; outputs checked at the next one.
    task automatic step(input logic [15:0] d, input logic lz);
        digit_in = d;
        blank_lz = lz;
        @(negedge clk);
        compare_all();
    endtask

    int          upd_cnt;
    int          first_upd;
    int          err_seen;
    bit          found;
    logic [15:0] val;
    logic [3:0]  dg;
    logic        lz;
    int          len;

    initial begin
        #1 reset = 1'b0;
        @(negedge clk);
        compare_all();
        @(negedge clk);
        compare_all();
        reset = 1'b1;

        // Basic scan of 1234 without blanking
        repeat (40) step(16'h1234, 1'b0);

        // Leading-zero blanking on and off
        repeat (20) step(16'h0007, 1'b1);
        repeat (20) step(16'h0007, 1'b0);

        // Single-cycle glitch must never reach the held set
        repeat (8) step(16'h0000, 1'b0);
        upd_cnt = 0;
        step(16'h0009, 1'b0);
        if (upd) upd_cnt++;
        for (int i = 0; i < 6; i++) begin
            step(16'h0000, 1'b0);
            if (upd) upd_cnt++;
        end
        check_eq("glitch_upd_cnt", upd_cnt, 0);

        // Stable change arrives four edges later with exactly one pulse
        upd_cnt   = 0;
        first_upd = 0;
        for (int i = 1; i <= 6; i++) begin
            step(16'h0009, 1'b0);
            if (upd) begin
                upd_cnt++;
                if (first_upd == 0) first_upd = i;
            end
        end
        check_eq("stable_upd_cnt", upd_cnt, 1);
        check_eq("stable_upd_latency", first_upd, 4);

        // Invalid digit shows a dash and raises dig_err
        repeat (12) step(16'h00A5, 1'b0);
        check_eq("dig_err_set", dig_err, 1'b1);
        repeat (12) step(16'h0005, 1'b0);
        check_eq("dig_err_clr", dig_err, 1'b0);

        // Asynchronous reset while digit 2 is enabled
        repeat (6) step(16'h1234, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (exp_an == 4'b1011) found = 1'b1;
            else step(16'h1234, 1'b0);
        end
        check_eq("find_an_1011", found, 1'b1);
        check_eq("pre_rst_an", an, 4'b1011);
        #2 reset = 1'b0;
        #1;
        check_eq("async_rst_an", an, 4'hF);
        check_eq("async_rst_seg", seg, 7'h7F);
        check_eq("async_rst_upd", upd, 1'b0);
        check_eq("async_rst_err", dig_err, 1'b0);
        @(negedge clk);
        compare_all();
        reset = 1'b1;
        @(negedge clk);
        compare_all();
        check_eq("first_an_after_rst", an, 4'b1110);

        // Ripple carries 9 -> 10 with short-lived transient codes
        err_seen = 0;
        for (int t = 0; t < 4; t++) begin
            repeat (6) begin
                step({8'h00, 4'(t), 4'h9}, 1'b0);
                if (dig_err) err_seen++;
            end
            upd_cnt = 0;
            step({8'h00, 4'(t), 4'h8}, 1'b0);
            if (upd) upd_cnt++;
            if (dig_err) err_seen++;
            step({8'h00, 4'(t), 4'hA}, 1'b0);
            if (upd) upd_cnt++;
            if (dig_err) err_seen++;
            step({8'h00, 4'(t), 4'h0}, 1'b0);
            if (upd) upd_cnt++;
            if (dig_err) err_seen++;
            repeat (6) begin
                step({8'h00, 4'(t + 1), 4'h0}, 1'b0);
                if (upd) upd_cnt++;
                if (dig_err) err_seen++;
            end
            check_eq("ripple_upd_cnt", upd_cnt, 1);
        end
        check_eq("ripple_dig_err", err_seen, 0);

        // Random digit words of random duration, blanking toggled at random
        for (int s = 0; s < 250; s++) begin
            val = 16'h0;
            for (int k = 0; k < NDIG; k++) begin
                dg = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                 : 4'($urandom_range(0, 9));
                val[4*k +: 4] = dg;
            end
            if ($urandom_range(0, 2) == 0) val = val & 16'h00FF;
            lz  = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 5);
            repeat (len) step(val, lz);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
